temporizador_jogada: RTL and testbench
======================================

Name: temporizador_jogada

Overview:
- Consumer end of the periodic-tick interface. Counts single-cycle tick pulses produced by the terminal-count (rco) output of the free-running tick counters.
- Arms on `iniciar`. Declares either a valid player move (`jogada_ok`) or a timeout (`timeout`) once LIMITE_TICKS ticks elapse without a move.
- Sits between the tick generator and the game control unit; replaces ad-hoc timeout logic in the control FSM.

Parameters:
- LIMITE_TICKS, 10: number of ticks allowed before timeout; legal range 1 .. 2^WIDTH-1.
- WIDTH, 8: width of the elapsed-tick counter.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- iniciar  in  1  arm/re-arm request, sampled on posedge.
- tick  in  1  tick pulse from the tick counter's rco; counted on every posedge where it is high.
- jogada  in  1  player-move event, sampled on posedge.
- ativo  out  1  high while in CONTANDO.
- jogada_ok  out  1  high for exactly one cycle (state FIM_OK).
- timeout  out  1  high for exactly one cycle (state FIM_TIMEOUT).
- ticks_decorridos  out  WIDTH  elapsed-tick count.
- estado_db  out  2  state code for debug display.

Behaviour:
- All outputs are registered or Moore-decoded from registered state; there is no combinational path from input to output.
- Reset (asynchronous, takes effect immediately, mid-operation included):
  - state = OCIOSO, counter = 0.
  - ativo = jogada_ok = timeout = 0, ticks_decorridos = 0, estado_db = 0.
- State encoding: OCIOSO = 0, CONTANDO = 1, FIM_OK = 2, FIM_TIMEOUT = 3.
- OCIOSO:
  - `tick` and `jogada` are ignored.
  - `iniciar` = 1 at a posedge -> next state CONTANDO, counter = 0.
  - Otherwise the state and counter hold; ticks_decorridos keeps the last run's value.
- CONTANDO: ativo = 1. Input priority per posedge is jogada > iniciar > tick.
  - `jogada` = 1 -> FIM_OK. The counter holds, and a tick in the same cycle is not counted.
  - Else `iniciar` = 1 -> stay in CONTANDO, counter = 0 (re-arm). A tick in the same cycle is not counted.
  - Else `tick` = 1:
    - counter = counter + 1.
    - If the old counter equals LIMITE_TICKS-1 -> FIM_TIMEOUT, and the counter ends at LIMITE_TICKS.
  - Else hold.
- FIM_OK: jogada_ok = 1 for one cycle, then unconditionally OCIOSO. Inputs are ignored in this cycle.
- FIM_TIMEOUT: timeout = 1 for one cycle, then unconditionally OCIOSO. Inputs are ignored in this cycle.
- Latency:
  - Move accepted at posedge N -> jogada_ok high during cycle N+1.
  - Final tick at posedge N -> timeout high during cycle N+1.
- Arithmetic and ranges:
  - The counter never exceeds LIMITE_TICKS and never wraps.
  - ticks_decorridos = counter, zero-extended to WIDTH.
- A `tick` held high for k cycles counts k ticks. The upstream source guarantees single-cycle pulses.
- With LIMITE_TICKS = 1, the first tick in CONTANDO causes timeout.

Optional Feature:
- Macro: TEMPORIZADOR_AVISO_EN.
- Defined:
  - Adds parameter AVISO_TICKS (default 3) and output port `aviso` (1 bit, registered).
  - aviso = 1 while state = CONTANDO and (LIMITE_TICKS - counter) <= AVISO_TICKS; otherwise 0.
  - aviso resets to 0.
- Undefined: neither the port nor the parameter exists. All other behaviour is identical.

Test Plan:
- Reset, then iniciar=1 for 1 cycle, then 10 ticks spaced 5 cycles apart, no jogada -> timeout=1 for exactly 1 cycle, one cycle after the 10th tick; ticks_decorridos=10; estado_db sequence 0,1,3,0; ativo low afterwards.
- Arm, 4 ticks, then jogada=1 -> jogada_ok=1 for 1 cycle; ticks_decorridos=4; timeout never asserts; later ticks are ignored in OCIOSO (count stays 4).
- Arm, 9 ticks, then jogada and tick asserted in the same cycle -> FIM_OK, jogada_ok=1; ticks_decorridos=9; no timeout.
- Arm, 7 ticks, iniciar=1 (re-arm), then 9 ticks -> no timeout, ticks_decorridos=9, ativo=1; a 10th tick -> timeout.
- Assert reset mid-CONTANDO at count 5 -> all outputs 0 immediately, before the next clock edge; a subsequent jogada with no iniciar produces no jogada_ok.
- With TEMPORIZADOR_AVISO_EN, AVISO_TICKS=3: arm, then ticks -> aviso rises once the count reaches 7; aviso=0 in FIM_TIMEOUT and OCIOSO; aviso never asserts if jogada arrives at count 6.

Source files
------------

// File: rtl/temporizador_jogada_if.sv
// Move-timer bus: arm/tick/move requests in, status and one-cycle verdict pulses out.
// With TEMPORIZADOR_AVISO_EN defined, the bus also carries the near-timeout warning `aviso`.
interface temporizador_jogada_if #(
   parameter int unsigned WIDTH = 8
);
   logic             iniciar;
   logic             tick;
   logic             jogada;
   logic             ativo;
   logic             jogada_ok;
   logic             timeout;
   logic [WIDTH-1:0] ticks_decorridos;
   logic [1:0]       estado_db;
`ifdef TEMPORIZADOR_AVISO_EN
   logic             aviso;
`endif

   modport master (
      output iniciar, tick, jogada,
      input  ativo, jogada_ok, timeout, ticks_decorridos, estado_db
`ifdef TEMPORIZADOR_AVISO_EN
      , input aviso
`endif
   );

   modport slave (
      input  iniciar, tick, jogada,
      output ativo, jogada_ok, timeout, ticks_decorridos, estado_db
`ifdef TEMPORIZADOR_AVISO_EN
      , output aviso
`endif
   );
endinterface

// File: rtl/temporizador_jogada.sv
// Move timer: counts rco ticks after arming and reports a player move or a timeout.
// Optional warning output enabled by defining TEMPORIZADOR_AVISO_EN.
module temporizador_jogada #(
   parameter int unsigned LIMITE_TICKS = 10,
   parameter int unsigned WIDTH        = 8
`ifdef TEMPORIZADOR_AVISO_EN
   , parameter int unsigned AVISO_TICKS = 3
`endif
) (
   input  logic                         clock,
   input  logic                         reset,
   temporizador_jogada_if.slave         bus
);

   typedef enum logic [1:0] {
      OCIOSO      = 2'd0,
      CONTANDO    = 2'd1,
      FIM_OK      = 2'd2,
      FIM_TIMEOUT = 2'd3
   } estado_t;

   localparam logic [WIDTH-1:0] LIMITE_M1 = WIDTH'(LIMITE_TICKS - 1);

   estado_t          estado_q, estado_d;
   logic [WIDTH-1:0] cont_q, cont_d;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q <= OCIOSO;
         cont_q   <= '0;
      end else begin
         estado_q <= estado_d;
         cont_q   <= cont_d;
      end
   end

   // Priority inside CONTANDO is move, then re-arm, then tick.
   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      unique case (estado_q)
         OCIOSO: begin
            if (bus.iniciar) begin
               estado_d = CONTANDO;
               cont_d   = '0;
            end
         end
         CONTANDO: begin
            if (bus.jogada) begin
               estado_d = FIM_OK;
            end else if (bus.iniciar) begin
               cont_d = '0;
            end else if (bus.tick) begin
               cont_d = cont_q + 1'b1;
               if (cont_q == LIMITE_M1) begin
                  estado_d = FIM_TIMEOUT;
               end
            end
         end
         FIM_OK:      estado_d = OCIOSO;
         FIM_TIMEOUT: estado_d = OCIOSO;
         default:     estado_d = OCIOSO;
      endcase
   end

   assign bus.ativo            = (estado_q == CONTANDO);
   assign bus.jogada_ok        = (estado_q == FIM_OK);
   assign bus.timeout          = (estado_q == FIM_TIMEOUT);
   assign bus.ticks_decorridos = cont_q;
   assign bus.estado_db        = estado_q;

`ifdef TEMPORIZADOR_AVISO_EN
   // Evaluated on next-state values so the register lines up with the state it describes.
   logic aviso_q, aviso_d;

   always_comb begin
      aviso_d = (estado_d == CONTANDO) &&
                ((LIMITE_TICKS - 32'(cont_d)) <= AVISO_TICKS);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         aviso_q <= 1'b0;
      end else begin
         aviso_q <= aviso_d;
      end
   end

   assign bus.aviso = aviso_q;
`endif

endmodule

// File: tb/tb_temporizador_jogada.sv
// Self-checking bench for temporizador_jogada: vector table, directed corner sequences,
// and random traffic against a reference model; aviso checks when TEMPORIZADOR_AVISO_EN is set.
module tb_temporizador_jogada;

   localparam int LIMITE = 10;
   localparam int AVISO  = 3;

   logic clock;
   logic reset;

   temporizador_jogada_if #(.WIDTH(8)) bus ();

   temporizador_jogada #(
      .LIMITE_TICKS(LIMITE),
      .WIDTH(8)
`ifdef TEMPORIZADOR_AVISO_EN
      , .AVISO_TICKS(AVISO)
`endif
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int nCompared;
   int nMismatched;

   // Reference model: a run is either armed and counting, or finished with one pending verdict pulse.
   bit mArmed;
   bit mOk;
   bit mTo;
   int mElapsed;

   typedef struct {
      logic       ini;
      logic       tk;
      logic       jg;
      logic       eAtivo;
      logic       eOk;
      logic       eTo;
      logic [7:0] eTicks;
      logic [1:0] eEst;
   } vec_t;

   vec_t vecs[9];

   task automatic checkOutput(input string name, input int actual, input int expected);
      nCompared++;
      if (actual != expected) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic modelReset();
      mArmed   = 1'b0;
      mOk      = 1'b0;
      mTo      = 1'b0;
      mElapsed = 0;
   endtask

   task automatic modelStep(input bit ini, input bit tk, input bit jg);
      if (mOk || mTo) begin
         mOk = 1'b0;
         mTo = 1'b0;
      end else if (!mArmed) begin
         if (ini) begin
            mArmed   = 1'b1;
            mElapsed = 0;
         end
      end else if (jg) begin
         mArmed = 1'b0;
         mOk    = 1'b1;
      end else if (ini) begin
         mElapsed = 0;
      end else if (tk) begin
         mElapsed++;
         if (mElapsed == LIMITE) begin
            mArmed = 1'b0;
            mTo    = 1'b1;
         end
      end
   endtask

   task automatic compareModel();
      int est;
      est = mArmed ? 1 : (mOk ? 2 : (mTo ? 3 : 0));
      checkOutput("model_ativo", int'(bus.ativo), int'(mArmed));
      checkOutput("model_jogada_ok", int'(bus.jogada_ok), int'(mOk));
      checkOutput("model_timeout", int'(bus.timeout), int'(mTo));
      checkOutput("model_ticks", int'(bus.ticks_decorridos), mElapsed);
      checkOutput("model_estado", int'(bus.estado_db), est);
`ifdef TEMPORIZADOR_AVISO_EN
      checkOutput("model_aviso", int'(bus.aviso), int'(mArmed && ((LIMITE - mElapsed) <= AVISO)));
`endif
   endtask

   // Drives one cycle of inputs, lets the edge happen, then checks against the model.
   task automatic applyStimulus(input bit ini, input bit tk, input bit jg);
      bus.iniciar = ini;
      bus.tick    = tk;
      bus.jogada  = jg;
      @(posedge clock);
      modelStep(ini, tk, jg);
      #1;
      compareModel();
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ativo"}, int'(bus.ativo), 0);
      checkOutput({tag, "_jogada_ok"}, int'(bus.jogada_ok), 0);
      checkOutput({tag, "_timeout"}, int'(bus.timeout), 0);
      checkOutput({tag, "_ticks"}, int'(bus.ticks_decorridos), 0);
      checkOutput({tag, "_estado"}, int'(bus.estado_db), 0);
`ifdef TEMPORIZADOR_AVISO_EN
      checkOutput({tag, "_aviso"}, int'(bus.aviso), 0);
`endif
   endtask

   task automatic doReset();
      bus.iniciar = 1'b0;
      bus.tick    = 1'b0;
      bus.jogada  = 1'b0;
      reset = 1'b1;
      modelReset();
      @(posedge clock);
      #1;
      checkAllZero("reset");
      reset = 1'b0;
   endtask

   task automatic tickN(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b1, 1'b0);
   endtask

   initial begin
      nCompared   = 0;
      nMismatched = 0;
      bus.iniciar = 1'b0;
      bus.tick    = 1'b0;
      bus.jogada  = 1'b0;
      reset       = 1'b0;
      modelReset();

      // Arm, four ticks, move, then ticks and a move ignored while idle.
      vecs[0] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 2'd1};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 2'd1};
      vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd2, 2'd1};
      vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3, 2'd1};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4, 2'd1};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'd4, 2'd2};
      vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 2'd0};
      vecs[7] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4, 2'd0};
      vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd4, 2'd0};

      #2;
      doReset();

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].ini, vecs[i].tk, vecs[i].jg);
         checkOutput($sformatf("vec%0d_ativo", i), int'(bus.ativo), int'(vecs[i].eAtivo));
         checkOutput($sformatf("vec%0d_ok", i), int'(bus.jogada_ok), int'(vecs[i].eOk));
         checkOutput($sformatf("vec%0d_timeout", i), int'(bus.timeout), int'(vecs[i].eTo));
         checkOutput($sformatf("vec%0d_ticks", i), int'(bus.ticks_decorridos), int'(vecs[i].eTicks));
         checkOutput($sformatf("vec%0d_estado", i), int'(bus.estado_db), int'(vecs[i].eEst));
      end

      // Full timeout with ticks spaced five cycles apart.
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < LIMITE; i++) begin
         repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
         applyStimulus(1'b0, 1'b1, 1'b0);
      end
      checkOutput("to_pulse", int'(bus.timeout), 1);
      checkOutput("to_ticks", int'(bus.ticks_decorridos), 10);
      checkOutput("to_estado", int'(bus.estado_db), 3);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("to_oneCycle", int'(bus.timeout), 0);
      checkOutput("to_ativoAfter", int'(bus.ativo), 0);
      checkOutput("to_estadoAfter", int'(bus.estado_db), 0);
      checkOutput("to_ticksHeld", int'(bus.ticks_decorridos), 10);

      // Move and final tick in the same cycle: the move wins.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tickN(LIMITE - 1);
      applyStimulus(1'b0, 1'b1, 1'b1);
      checkOutput("tie_ok", int'(bus.jogada_ok), 1);
      checkOutput("tie_ticks", int'(bus.ticks_decorridos), 9);
      checkOutput("tie_timeout", int'(bus.timeout), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Re-arm mid-run restarts the count; tick in the re-arm cycle is dropped.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tickN(7);
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput("rearm_ticks0", int'(bus.ticks_decorridos), 0);
      tickN(9);
      checkOutput("rearm_ativo", int'(bus.ativo), 1);
      checkOutput("rearm_ticks9", int'(bus.ticks_decorridos), 9);
      checkOutput("rearm_noTimeout", int'(bus.timeout), 0);
      tickN(1);
      checkOutput("rearm_timeout", int'(bus.timeout), 1);
      checkOutput("rearm_ticks10", int'(bus.ticks_decorridos), 10);
      applyStimulus(1'b0, 1'b0, 1'b0);

      // Asynchronous reset at count 5, observed before the next edge.
      applyStimulus(1'b1, 1'b0, 1'b0);
      tickN(5);
      checkOutput("async_pre", int'(bus.ticks_decorridos), 5);
      #3;
      reset = 1'b1;
      modelReset();
      #1;
      checkAllZero("async");
      @(posedge clock);
      #1;
      reset = 1'b0;
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("async_noOk", int'(bus.jogada_ok), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("async_stillIdle", int'(bus.estado_db), 0);

`ifdef TEMPORIZADOR_AVISO_EN
      // Warning window covers the last AVISO_TICKS counts of a run.
      applyStimulus(1'b1, 1'b0, 1'b0);
      checkOutput("aviso_arm", int'(bus.aviso), 0);
      for (int i = 1; i <= LIMITE; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("aviso_cnt%0d", i), int'(bus.aviso), int'(i >= 7 && i < LIMITE));
      end
      applyStimulus(1'b0, 1'b0, 1'b0);
      checkOutput("aviso_idle", int'(bus.aviso), 0);
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 6; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0);
         checkOutput($sformatf("aviso_early%0d", i), int'(bus.aviso), 0);
      end
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("aviso_okCycle", int'(bus.aviso), 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
`endif

      // Random traffic with sparse arms and moves against the reference model.
      for (int i = 0; i < 800; i++) begin
         applyStimulus(($urandom_range(99) < 6), ($urandom_range(99) < 30),
                       ($urandom_range(99) < 3));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
